// File: rtl/chk_pkg.sv
// Shared state encoding, stimulus limits and event-width helper for the sweep response checker.
package chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] X_MAX = 3'd7;

    // Event word layout is {x, fmis, gmis}.
    function automatic int EV_W(input int n);
        return 3 + 2 * n;
    endfunction

endpackage

// File: rtl/chk_event_fifo.sv
// Synchronous push/pop event FIFO; a simultaneous push and pop are both honoured when full.
module chk_event_fifo #(
    parameter int DEPTH = 8,
    parameter int EV_W  = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [EV_W-1:0] wdata_i,
    output logic [EV_W-1:0] rdata_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [EV_W-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // An empty FIFO presents zero rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sweep_response_checker.sv
// Flags DUTs whose f/g outputs disagree with a chosen reference over SWEEPS wraps of x.
// Defining CHK_EVENT_FIFO_EN adds the per-cycle mismatch event FIFO.
module sweep_response_checker
    import chk_pkg::*;
#(
    parameter int N_DUT  = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int SWEEPS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             ref_sel,
    input  logic [2:0]             x,
    input  logic [N_DUT-1:0]       f,
    input  logic [N_DUT-1:0]       g,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [N_DUT-1:0]       err_mask,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [EV_W(N_DUT)-1:0] ev_data,
    output logic                   overflow
);

    localparam int EVW    = EV_W(N_DUT);
    localparam int WRAP_W = $clog2(SWEEPS + 1);
    localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(SWEEPS - 1);

    state_e            state_q, state_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [1:0]        ref_q, ref_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [N_DUT-1:0]  err_mask_q, err_mask_d;
    logic [2:0]        x_q;

    logic [N_DUT-1:0]  fmis, gmis;
    logic [EVW-1:0]    ev_word;
    logic              mis_any, wrap_hit, start_ok, check_en, push_ev;

    assign fmis     = f ^ {N_DUT{f[ref_q]}};
    assign gmis     = g ^ {N_DUT{g[ref_q]}};
    assign mis_any  = |{fmis, gmis};
    assign wrap_hit = (x_q == X_MAX) && (x == 3'd0);
    assign ev_word  = {x, fmis, gmis};
    assign push_ev  = check_en && mis_any;

    // The edge that completes the final wrap ends the run and is not itself checked.
    always_comb begin
        state_d    = state_q;
        wrap_d     = wrap_q;
        ref_d      = ref_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        start_ok   = 1'b0;
        check_en   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_ARM;
                    start_ok   = 1'b1;
                    wrap_d     = '0;
                    ref_d      = ref_sel;
                    err_cnt_d  = '0;
                    err_mask_d = '0;
                end
            end
            ST_ARM: begin
                if (x == 3'd0) state_d = ST_RUN;
            end
            ST_RUN: begin
                check_en = 1'b1;
                if (wrap_hit) begin
                    if (wrap_q == WRAP_LAST) begin
                        state_d  = ST_DONE;
                        check_en = 1'b0;
                    end else begin
                        wrap_d = wrap_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (check_en && mis_any) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            err_mask_d = err_mask_q | fmis | gmis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wrap_q     <= '0;
            ref_q      <= '0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            x_q        <= '0;
        end else begin
            state_q    <= state_d;
            wrap_q     <= wrap_d;
            ref_q      <= ref_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            x_q        <= x;
        end
    end

    assign busy     = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign err_cnt  = err_cnt_q;
    assign err_mask = err_mask_q;

`ifdef CHK_EVENT_FIFO_EN
    logic fifo_full, fifo_empty, fifo_pop, overflow_q;

    assign fifo_pop = ev_ready && !fifo_empty;

    chk_event_fifo #(
        .DEPTH (DEPTH),
        .EV_W  (EVW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_ok),
        .push_i  (push_ev),
        .pop_i   (fifo_pop),
        .wdata_i (ev_word),
        .rdata_o (ev_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A push into a full FIFO survives only if the same edge frees a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (start_ok) begin
            overflow_q <= 1'b0;
        end else if (push_ev && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign ev_valid = !fifo_empty;
    assign overflow = overflow_q;
`else
    logic unused_fifo_inputs;

    assign unused_fifo_inputs = ev_ready ^ push_ev ^ start_ok ^ (^ev_word);
    assign ev_valid = 1'b0;
    assign ev_data  = '0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_response_checker.sv
// Scoreboard bench for sweep_response_checker; adapts its event expectations to CHK_EVENT_FIFO_EN.
module tb_sweep_response_checker;

    localparam int N_DUT  = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;
    localparam int SWEEPS = 2;
    localparam int EVW    = 3 + 2 * N_DUT;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;
`ifdef CHK_EVENT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       ref_sel;
    logic [2:0]       x;
    logic [N_DUT-1:0] f, g;
    logic             busy, done, ev_valid, ev_ready, overflow;
    logic [CNT_W-1:0] err_cnt;
    logic [N_DUT-1:0] err_mask;
    logic [EVW-1:0]   ev_data;

    int               n_cmp, n_bad;
    int               cur_mode;
    int               m_state, m_wraps;
    logic [1:0]       m_ref;
    logic [2:0]       m_prevx;
    logic [CNT_W-1:0] m_cnt;
    logic [N_DUT-1:0] m_mask;
    logic             m_ovf;
    logic             rdy_latched;
    logic [EVW-1:0]   ev_q[$];

    sweep_response_checker #(
        .N_DUT  (N_DUT),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .SWEEPS (SWEEPS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ref_sel  (ref_sel),
        .x        (x),
        .f        (f),
        .g        (g),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt),
        .err_mask (err_mask),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .overflow (overflow)
    );

    always #10 clk = ~clk;

    // Drive one cycle at the falling edge, predict the rising edge, then check all outputs.
    task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
        logic [N_DUT-1:0] fb, gb, fm, gm;
        logic             chk, exp_busy, exp_done, exp_valid;
        logic [EVW-1:0]   exp_data;
        @(negedge clk);
        reset    = rst;
        start    = st;
        ev_ready = rdy;
        x        = x + 3'd1;
        fb = ($urandom_range(0, 1) != 0) ? '1 : '0;
        gb = ($urandom_range(0, 1) != 0) ? '1 : '0;
        case (cur_mode)
            1:       begin f = fb ^ ((x == 3'd3) ? 4'b0100 : 4'b0000); g = gb; end
            2:       begin f = fb ^ 4'b1000; g = gb; end
            3:       begin f = N_DUT'($urandom); g = N_DUT'($urandom); end
            default: begin f = fb; g = gb; end
        endcase
        if (rst) begin
            m_state = M_IDLE;
            m_cnt   = '0;
            m_mask  = '0;
            m_ovf   = 1'b0;
            ev_q.delete();
        end else begin
            if (rdy && ev_q.size() > 0) void'(ev_q.pop_front());
            case (m_state)
                M_ARM: if (x == 3'd0) m_state = M_RUN;
                M_RUN: begin
                    chk = 1'b1;
                    if (m_prevx == 3'd7 && x == 3'd0) begin
                        m_wraps++;
                        if (m_wraps == SWEEPS) begin
                            m_state = M_DONE;
                            chk     = 1'b0;
                        end
                    end
                    if (chk) begin
                        for (int i = 0; i < N_DUT; i++) begin
                            fm[i] = f[i] ^ f[m_ref];
                            gm[i] = g[i] ^ g[m_ref];
                        end
                        if ((fm | gm) != '0) begin
                            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                            m_mask = m_mask | fm | gm;
                            if (FIFO_EN) begin
                                if (ev_q.size() < DEPTH) ev_q.push_back({x, fm, gm});
                                else m_ovf = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (st) begin
                        m_state = M_ARM;
                        m_wraps = 0;
                        m_cnt   = '0;
                        m_mask  = '0;
                        m_ovf   = 1'b0;
                        m_ref   = ref_sel;
                        ev_q.delete();
                    end
                end
            endcase
        end
        m_prevx = x;
        @(posedge clk);
        #1;
        exp_busy  = (m_state == M_ARM) || (m_state == M_RUN);
        exp_done  = (m_state == M_DONE);
        exp_valid = FIFO_EN && (ev_q.size() != 0);
        exp_data  = exp_valid ? ev_q[0] : '0;
        n_cmp++;
        if (busy !== exp_busy) begin
            n_bad++;
            $display("[TB] FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
        end
        n_cmp++;
        if (done !== exp_done) begin
            n_bad++;
            $display("[TB] FAIL done: got %b expected %b at %0t", done, exp_done, $time);
        end
        n_cmp++;
        if (err_cnt !== m_cnt) begin
            n_bad++;
            $display("[TB] FAIL err_cnt: got %0d expected %0d at %0t", err_cnt, m_cnt, $time);
        end
        n_cmp++;
        if (err_mask !== m_mask) begin
            n_bad++;
            $display("[TB] FAIL err_mask: got %b expected %b at %0t", err_mask, m_mask, $time);
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_bad++;
            $display("[TB] FAIL overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
        end
        n_cmp++;
        if (ev_valid !== exp_valid) begin
            n_bad++;
            $display("[TB] FAIL ev_valid: got %b expected %b at %0t", ev_valid, exp_valid, $time);
        end
        n_cmp++;
        if (ev_data !== exp_data) begin
            n_bad++;
            $display("[TB] FAIL ev_data: got %h expected %h at %0t", ev_data, exp_data, $time);
        end
    endtask

    function automatic logic ready_for(input int rpol);
        if (rpol == 0) return 1'b1;
        if (rpol == 1) return 1'b0;
        if (ev_q.size() >= DEPTH) rdy_latched = 1'b1;
        return rdy_latched;
    endfunction

    // Start a run and clock it to DONE, optionally re-pulsing start mid-run or aborting by reset.
    task automatic run_sweep(input int mode, input logic [1:0] rs, input int rpol,
                             input int restart_at, input int abort_cnt);
        int guard;
        guard    = 0;
        cur_mode = mode;
        ref_sel  = rs;
        applyStimulus(1'b1, (rpol == 0), 1'b0);
        while (m_state != M_DONE && guard < 60) begin
            if (abort_cnt > 0 && m_cnt == CNT_W'(abort_cnt)) begin
                applyStimulus(1'b0, ready_for(rpol), 1'b1);
                return;
            end
            applyStimulus(guard == restart_at, ready_for(rpol), 1'b0);
            guard++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL run_end: done=%b after %0d cycles, required 1", done, guard);
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({busy, done, ev_valid, overflow} !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got %b required 0000", {busy, done, ev_valid, overflow});
        end
        n_cmp++;
        if (err_cnt !== '0 || err_mask !== '0 || ev_data !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_values: cnt=%0d mask=%b data=%h required all zero",
                     err_cnt, err_mask, ev_data);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clean_sweep();
        run_sweep(0, 2'd0, 0, -1, 0);
        n_cmp++;
        if (err_cnt !== '0 || err_mask !== '0 || ev_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL clean_sweep: cnt=%0d mask=%b valid=%b required 0/0000/0",
                     err_cnt, err_mask, ev_valid);
        end
    endtask

    task automatic test_single_mismatch();
        run_sweep(1, 2'd0, 0, -1, 0);
        n_cmp++;
        if (err_cnt !== 16'd2) begin
            n_bad++;
            $display("[TB] FAIL x3_count: got %0d required 2", err_cnt);
        end
        n_cmp++;
        if (err_mask !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL x3_mask: got %b required 0100", err_mask);
        end
    endtask

    task automatic test_back_to_back();
        run_sweep(0, 2'd1, 0, -1, 0);
        n_cmp++;
        if (err_cnt !== '0 || err_mask !== '0) begin
            n_bad++;
            $display("[TB] FAIL restart_clear: cnt=%0d mask=%b required 0/0000", err_cnt, err_mask);
        end
    endtask

    task automatic test_overflow();
        run_sweep(2, 2'd0, 1, -1, 0);
        n_cmp++;
        if (err_mask !== 4'b1000 || err_cnt !== m_cnt) begin
            n_bad++;
            $display("[TB] FAIL ovf_totals: cnt=%0d mask=%b required %0d/1000", err_cnt, err_mask, m_cnt);
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_bad++;
            $display("[TB] FAIL ovf_flag: got %b required %b", overflow, m_ovf);
        end
    endtask

    task automatic test_full_stream();
        rdy_latched = 1'b0;
        run_sweep(2, 2'd0, 2, -1, 0);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL stream_no_ovf: got %b required 0", overflow);
        end
        for (int i = 0; i < DEPTH + 4 && ev_q.size() > 0; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL drain_empty: ev_valid=%b required 0", ev_valid);
        end
    endtask

    task automatic test_reset_midrun();
        run_sweep(2, 2'd0, 0, -1, 5);
        n_cmp++;
        if (busy !== 1'b0 || err_cnt !== '0 || ev_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_state: busy=%b cnt=%0d valid=%b required 0/0/0",
                     busy, err_cnt, ev_valid);
        end
        run_sweep(1, 2'd0, 0, -1, 0);
        n_cmp++;
        if (err_cnt !== 16'd2 || err_mask !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL rearm_run: cnt=%0d mask=%b required 2/0100", err_cnt, err_mask);
        end
    endtask

    task automatic test_random_ref();
        run_sweep(3, 2'd2, 0, 6, 0);
        n_cmp++;
        if (err_mask[2] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ref_bit_clear: err_mask[2]=%b required 0", err_mask[2]);
        end
        n_cmp++;
        if (err_cnt !== m_cnt || err_mask !== m_mask) begin
            n_bad++;
            $display("[TB] FAIL random_totals: cnt=%0d mask=%b required %0d/%b",
                     err_cnt, err_mask, m_cnt, m_mask);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        start       = 1'b0;
        ref_sel     = 2'd0;
        x           = 3'd0;
        f           = '0;
        g           = '0;
        ev_ready    = 1'b0;
        cur_mode    = 0;
        m_state     = M_IDLE;
        m_wraps     = 0;
        m_ref       = 2'd0;
        m_prevx     = 3'd0;
        m_cnt       = '0;
        m_mask      = '0;
        m_ovf       = 1'b0;
        rdy_latched = 1'b0;
        test_reset();
        test_clean_sweep();
        test_single_mismatch();
        test_back_to_back();
        test_overflow();
        test_full_stream();
        test_reset_midrun();
        test_random_ref();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
